// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan of four 7-segment digits.
// Each digit slot opens with a blanking gap, then lights one digit.
// CPU writes land in a pending buffer and are committed to the active
// buffer only at the end of a frame, so a frame never mixes old and new data.
module display_scan_ctrl #(
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] disp0,
  input  logic [7:0] disp1,
  input  logic [7:0] disp2,
  input  logic [7:0] disp3,
  input  logic       wr_en,
  output logic       wr_ack,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int CW = $clog2(PRESCALE);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYC - 1);
  localparam cnt_t SLOT_LAST  = cnt_t'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             commit;

  logic [3:0][7:0]  disp_w;
  logic [3:0][7:0]  pend_q, act_q;
  logic             pflag_q;

  logic [3:0]       an_d;
  logic [7:0]       seg_d;
  logic             ack_d, fs_d;

  assign disp_w = {disp3, disp2, disp1, disp0};

  // State register: FSM state, slot counter and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      digit_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  // Next-state logic; commit fires on the final cycle of digit 3's slot
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    commit  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      digit_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
        S_BLANK: begin
          cnt_d = cnt_q + cnt_t'(1);
          if (cnt_q == BLANK_LAST) state_d = S_SHOW;
        end
        S_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            commit  = (digit_q == 2'd3);
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so every output is registered
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 8'hFF;
    if (state_d == S_SHOW) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = ~act_q[digit_d];
    end
    fs_d  = (state_d == S_BLANK) && (digit_d == 2'd0) && (cnt_d == '0);
    ack_d = commit && (pflag_q || wr_en);
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an          <= 4'b1111;
      seg         <= 8'hFF;
      wr_ack      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an          <= an_d;
      seg         <= seg_d;
      wr_ack      <= ack_d;
      frame_start <= fs_d;
    end
  end

  // Double buffer: a write on the commit cycle bypasses straight to active
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= '0;
      act_q   <= '0;
      pflag_q <= 1'b0;
    end else if (commit) begin
      if (wr_en)        act_q <= disp_w;
      else if (pflag_q) act_q <= pend_q;
      if (wr_en)        pend_q <= disp_w;
      pflag_q <= 1'b0;
    end else if (wr_en) begin
      pend_q  <= disp_w;
      pflag_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position reference model plus directed
// literal checks, followed by randomized enable/write/reset traffic.
module tb_display_scan_ctrl;
  localparam int P = 8;
  localparam int B = 2;
  localparam int FR = 4 * P;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] dv [4];
  logic       wr_ack, frame_start;
  logic [7:0] seg;
  logic [3:0] an;

  int n_cmp = 0;
  int n_err = 0;

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .disp0(dv[0]), .disp1(dv[1]), .disp2(dv[2]), .disp3(dv[3]),
    .wr_en(wr_en), .wr_ack(wr_ack), .seg(seg), .an(an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // reference model: position within the frame, plus the two buffers
  bit         m_on;
  int         m_pos;
  bit         m_flag;
  logic [7:0] m_pend [4];
  logic [7:0] m_act  [4];
  logic       e_ack, e_fs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pos = 0; m_flag = 0; e_ack = 0; e_fs = 0;
    for (int i = 0; i < 4; i++) begin m_pend[i] = 8'h00; m_act[i] = 8'h00; end
  endtask

  task automatic model_step();
    bit commit;
    if (!enable) begin
      m_on = 0; m_pos = 0; e_ack = 0; e_fs = 0;
      if (wr_en) begin
        for (int i = 0; i < 4; i++) m_pend[i] = dv[i];
        m_flag = 1;
      end
    end else begin
      commit = m_on && (m_pos == FR - 1);
      m_pos  = m_on ? (m_pos + 1) % FR : 0;
      m_on   = 1;
      e_fs   = (m_pos == 0);
      e_ack  = commit && (m_flag || wr_en);
      if (commit) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_en)       m_act[i] = dv[i];
          else if (m_flag) m_act[i] = m_pend[i];
          if (wr_en)       m_pend[i] = dv[i];
        end
        m_flag = 0;
      end else if (wr_en) begin
        for (int i = 0; i < 4; i++) m_pend[i] = dv[i];
        m_flag = 1;
      end
    end
  endtask

  // the single compare process: advance the model on each edge, check #1 later
  always @(posedge clk) begin
    logic [3:0] e_an;
    logic [7:0] e_seg;
    int d;
    if (!reset) model_reset();
    else        model_step();
    e_an = 4'b1111; e_seg = 8'hFF;
    if (m_on && (m_pos % P) >= B) begin
      d     = m_pos / P;
      e_an  = ~(4'b0001 << d);
      e_seg = ~m_act[d];
    end
    #1;
    chk("model_an", {28'd0, an}, {28'd0, e_an});
    chk("model_seg", {24'd0, seg}, {24'd0, e_seg});
    chk("model_wr_ack", {31'd0, wr_ack}, {31'd0, e_ack});
    chk("model_frame_start", {31'd0, frame_start}, {31'd0, e_fs});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_disp(input logic [7:0] a, b, c, e);
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = e;
  endtask

  task automatic lit(input string nm, input logic [3:0] ea, input logic [7:0] es,
                     input logic eack, input logic efs);
    chk({nm, "_an"}, {28'd0, an}, {28'd0, ea});
    chk({nm, "_seg"}, {24'd0, seg}, {24'd0, es});
    chk({nm, "_ack"}, {31'd0, wr_ack}, {31'd0, eack});
    chk({nm, "_fs"}, {31'd0, frame_start}, {31'd0, efs});
  endtask

  initial begin
    set_disp(8'h00, 8'h00, 8'h00, 8'h00);
    step(3);
    reset = 1'b1;
    step(4);
    lit("idle_after_reset", 4'hF, 8'hFF, 1'b0, 1'b0);

    // scan order: enable and write the first display set together
    enable = 1'b1; wr_en = 1'b1; set_disp(8'h3F, 8'h06, 8'h5B, 8'h4F);
    step(1); wr_en = 1'b0;
    lit("first_blank", 4'hF, 8'hFF, 1'b0, 1'b1);
    step(31); step(1);
    lit("first_commit", 4'hF, 8'hFF, 1'b1, 1'b1);
    step(1);  lit("slot0_blank1", 4'hF, 8'hFF, 1'b0, 1'b0);
    step(1);  lit("digit0", 4'hE, 8'hC0, 1'b0, 1'b0);
    step(8);  lit("digit1", 4'hD, 8'hF9, 1'b0, 1'b0);
    step(8);  lit("digit2", 4'hB, 8'hA4, 1'b0, 1'b0);
    step(8);  lit("digit3", 4'h7, 8'hB0, 1'b0, 1'b0);
    step(6);  lit("frame_period", 4'hF, 8'hFF, 1'b0, 1'b1);

    // tear-free update written mid digit-1 show
    step(11); wr_en = 1'b1; set_disp(8'h3F, 8'h7F, 8'h5B, 8'h4F);
    step(1);  wr_en = 1'b0;
    lit("tear_hold_a", 4'hD, 8'hF9, 1'b0, 1'b0);
    step(3);  lit("tear_hold_b", 4'hD, 8'hF9, 1'b0, 1'b0);
    step(17); lit("tear_commit", 4'hF, 8'hFF, 1'b1, 1'b1);
    step(10); lit("tear_new", 4'hD, 8'h80, 1'b0, 1'b0);

    // two writes in one frame, one ack
    wr_en = 1'b1; set_disp(8'h01, 8'h7F, 8'h5B, 8'h4F);
    step(1); wr_en = 1'b0;
    step(2); wr_en = 1'b1; set_disp(8'h02, 8'h7F, 8'h5B, 8'h4F);
    step(1); wr_en = 1'b0;
    step(18); lit("multi_commit", 4'hF, 8'hFF, 1'b1, 1'b1);
    step(1);  lit("multi_single_ack", 4'hF, 8'hFF, 1'b0, 1'b0);
    step(1);  lit("multi_value", 4'hE, 8'hFD, 1'b0, 1'b0);

    // write on the commit cycle itself
    step(29); lit("commit_cycle_pos", 4'h7, 8'hB0, 1'b0, 1'b0);
    wr_en = 1'b1; set_disp(8'h77, 8'h7F, 8'h5B, 8'h4F);
    step(1);  wr_en = 1'b0;
    lit("bypass_ack", 4'hF, 8'hFF, 1'b1, 1'b1);
    step(2);  lit("bypass_value", 4'hE, 8'h88, 1'b0, 1'b0);
    step(30); lit("bypass_no_second_ack", 4'hF, 8'hFF, 1'b0, 1'b1);

    // enable drop with a pending write held
    wr_en = 1'b1; set_disp(8'h11, 8'h7F, 8'h5B, 8'h4F);
    step(1);  wr_en = 1'b0;
    step(18); lit("drop_digit2", 4'hB, 8'hA4, 1'b0, 1'b0);
    enable = 1'b0;
    step(1);  lit("drop_idle", 4'hF, 8'hFF, 1'b0, 1'b0);
    step(5);
    enable = 1'b1;
    step(1);  lit("reenable", 4'hF, 8'hFF, 1'b0, 1'b1);
    step(32); lit("pending_commit", 4'hF, 8'hFF, 1'b1, 1'b1);
    step(2);  lit("pending_value", 4'hE, 8'hEE, 1'b0, 1'b0);

    // asynchronous reset in the middle of a show slot
    reset = 1'b0; enable = 1'b0;
    #1; lit("async_reset", 4'hF, 8'hFF, 1'b0, 1'b0);
    step(3);
    reset = 1'b1;
    step(20); lit("idle_20", 4'hF, 8'hFF, 1'b0, 1'b0);

    // randomized traffic checked by the model
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(499) == 0) reset = 1'b0;
      if (enable) begin
        if ($urandom_range(149) == 0) enable = 1'b0;
      end else if ($urandom_range(5) == 0) enable = 1'b1;
      wr_en = ($urandom_range(19) == 0);
      for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
    end
    wr_en = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
